image_streamer: RTL

IMAGE_STREAMER -- requirements
Module: image_streamer

---
 rtl/image_streamer.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/image_streamer.sv
// Raster frame reader for a binary morphology line-buffer chain: pixel memory out, zero pad rows after each frame.
// Latency: pixel leaves one cycle after its read/pad slot; i_pixel_en paces slots, no slot means no valid.
module image_streamer #(
    parameter int dataWidth   = 1,
    parameter int imageWidth  = 512,
    parameter int imageHeight = 512,
    parameter int padLines    = 1,
    parameter int addrWidth   = 18
) (
    input  logic                 i_clk,
    input  logic                 i_rstn,
    input  logic                 i_start,
    input  logic                 i_pixel_en,
    output logic                 o_mem_rd_en,
    output logic [addrWidth-1:0] o_mem_addr,
    input  logic [dataWidth-1:0] i_mem_data,
    output logic [dataWidth-1:0] o_data,
    output logic                 o_data_valid,
    output logic                 o_sof,
    output logic                 o_eol,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int ColW = (imageWidth > 1) ? $clog2(imageWidth) : 1;
    localparam int RowW = $clog2(imageHeight + padLines + 1);

    typedef enum logic [1:0] {IDLE, READ, PAD, FINISH} state_t;

    state_t               state_q, state_d;
    logic [addrWidth-1:0] addr_q, addr_d;
    logic [ColW-1:0]      col_q, col_d;
    logic [RowW-1:0]      row_q, row_d;
    logic                 fin_q, fin_d;
    logic                 vld_q, vld_d;
    logic                 pad_q, pad_d;
    logic                 sof_q, sof_d;
    logic                 eol_q, eol_d;
    logic                 rd_en, done;
    logic                 col_last, row_last_img, row_last_pad;

    assign col_last     = (col_q == ColW'(imageWidth - 1));
    assign row_last_img = (row_q == RowW'(imageHeight - 1));
    // Pad rows continue the row count past the image so no separate pad counter is needed.
    assign row_last_pad = (row_q == RowW'(imageHeight + padLines - 1));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        col_d   = col_q;
        row_d   = row_q;
        fin_d   = fin_q;
        rd_en   = 1'b0;
        done    = 1'b0;
        vld_d   = ((state_q == READ) || (state_q == PAD)) && i_pixel_en;
        pad_d   = (state_q == PAD) && i_pixel_en;
        sof_d   = (state_q == READ) && i_pixel_en && (addr_q == '0);
        eol_d   = vld_d && col_last;

        if (vld_d) begin
            if (col_last) begin
                col_d = '0;
                row_d = row_q + RowW'(1);
            end else begin
                col_d = col_q + ColW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                fin_d = 1'b0;
                if (i_start) begin
                    state_d = READ;
                    addr_d  = '0;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            READ: begin
                if (i_pixel_en) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + addrWidth'(1);
                    if (col_last && row_last_img) begin
                        state_d = (padLines > 0) ? PAD : FINISH;
                    end
                end
            end
            PAD: begin
                if (i_pixel_en && col_last && row_last_pad) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                // First cycle lets the final registered pixel drain; second cycle signals completion.
                if (!fin_q) begin
                    fin_d = 1'b1;
                end else begin
                    fin_d   = 1'b0;
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            col_q   <= '0;
            row_q   <= '0;
            fin_q   <= 1'b0;
            vld_q   <= 1'b0;
            pad_q   <= 1'b0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            col_q   <= col_d;
            row_q   <= row_d;
            fin_q   <= fin_d;
            vld_q   <= vld_d;
            pad_q   <= pad_d;
            sof_q   <= sof_d;
            eol_q   <= eol_d;
        end
    end

    // Memory returns data registered one cycle after the strobe, aligned with vld_q.
    assign o_data       = (vld_q && !pad_q) ? i_mem_data : '0;
    assign o_data_valid = vld_q;
    assign o_sof        = sof_q;
    assign o_eol        = eol_q;
    assign o_mem_rd_en  = rd_en;
    assign o_mem_addr   = addr_q;
    assign o_busy       = (state_q != IDLE);
    assign o_done       = done;

endmodule
